// File: rtl/etc1_block_sequencer_if.sv
// rtl/etc1_block_sequencer_if.sv - Block input, decoder drive and pixel output bundle for etc1_block_sequencer.
interface etc1_block_sequencer_if;
  logic [63:0] in_block;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dec_block;
  logic [1:0]  dec_x;
  logic [1:0]  dec_y;
  logic [23:0] dec_pixel;
  logic [23:0] out_pixel;
  logic [1:0]  out_x;
  logic [1:0]  out_y;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport slave (
    input  in_block, in_valid, dec_pixel, out_ready,
    output in_ready, dec_block, dec_x, dec_y,
    output out_pixel, out_x, out_y, out_last, out_valid, busy
  );

  modport master (
    output in_block, in_valid, dec_pixel, out_ready,
    input  in_ready, dec_block, dec_x, dec_y,
    input  out_pixel, out_x, out_y, out_last, out_valid, busy
  );
endinterface

// File: rtl/etc1_block_sequencer.sv
// rtl/etc1_block_sequencer.sv - Walks the 16 texels of each ETC1 block through an external decoder
// and re-aligns decoded pixels with their coordinates on a backpressured output stream.
module etc1_block_sequencer #(
  parameter int DEC_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  etc1_block_sequencer_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + DEC_LATENCY + 2) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed { logic vld; logic [1:0] x; logic [1:0] y; logic last; } tag_t;
  typedef struct packed { logic [23:0] pixel; logic [1:0] x; logic [1:0] y; logic last; } beat_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [63:0]             blk_q, blk_d;
  logic [63:0]             dec_block_q, dec_block_d;
  logic [1:0]              dec_x_q, dec_x_d, dec_y_q, dec_y_d;
  logic                    iss_vld_q, iss_vld_d, iss_last_q, iss_last_d;
  tag_t  [DEC_LATENCY-1:0] pipe_q, pipe_d;
  beat_t [FIFO_DEPTH-1:0]  fifo_q, fifo_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        count_q, count_d;

  logic [OCC_W-1:0] occ;
  logic             issue, push, pop, in_ready_raw, in_flight_any;
  tag_t             tail;
  beat_t            head;

  // Credit covers the issue register and every decoder stage, so an issued texel always owns a FIFO slot.
  always_comb begin
    occ           = count_q + OCC_W'(iss_vld_q);
    in_flight_any = iss_vld_q;
    for (int i = 0; i < DEC_LATENCY; i++) begin
      occ           = occ + OCC_W'(pipe_q[i].vld);
      in_flight_any = in_flight_any | pipe_q[i].vld;
    end
    issue = (state_q == ISSUE) && (occ < DEPTH_C);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    dec_block_d  = dec_block_q;
    dec_x_d      = dec_x_q;
    dec_y_d      = dec_y_q;
    iss_vld_d    = 1'b0;
    iss_last_d   = 1'b0;
    in_ready_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_raw = 1'b1;
        if (bus.in_valid) begin
          blk_d       = bus.in_block;
          dec_block_d = bus.in_block;
          idx_d       = 4'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          dec_block_d = blk_q;
          dec_x_d     = idx_q[1:0];
          dec_y_d     = idx_q[3:2];
          iss_vld_d   = 1'b1;
          iss_last_d  = (idx_q == 4'd15);
          idx_d       = idx_q + 4'd1;
          // The next block is taken on the last issue so texel 0 follows texel 15 with no bubble.
          if (idx_q == 4'd15) begin
            in_ready_raw = 1'b1;
            if (bus.in_valid) blk_d = bus.in_block;
            else              state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = '{vld: iss_vld_q, x: dec_x_q, y: dec_y_q, last: iss_last_q};
    for (int i = 1; i < DEC_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    tail     = pipe_q[DEC_LATENCY-1];
    push     = tail.vld;
    pop      = (count_q != '0) && bus.out_ready;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{pixel: bus.dec_pixel, x: tail.x, y: tail.y, last: tail.last};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + OCC_W'(push) - OCC_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      blk_q       <= '0;
      dec_block_q <= '0;
      dec_x_q     <= '0;
      dec_y_q     <= '0;
      iss_vld_q   <= 1'b0;
      iss_last_q  <= 1'b0;
      pipe_q      <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      blk_q       <= blk_d;
      dec_block_q <= dec_block_d;
      dec_x_q     <= dec_x_d;
      dec_y_q     <= dec_y_d;
      iss_vld_q   <= iss_vld_d;
      iss_last_q  <= iss_last_d;
      pipe_q      <= pipe_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign bus.in_ready  = in_ready_raw && !reset;
  assign bus.dec_block = dec_block_q;
  assign bus.dec_x     = dec_x_q;
  assign bus.dec_y     = dec_y_q;
  assign bus.out_pixel = head.pixel;
  assign bus.out_x     = head.x;
  assign bus.out_y     = head.y;
  assign bus.out_last  = head.last;
  assign bus.out_valid = (count_q != '0);
  assign bus.busy      = (state_q == ISSUE) || in_flight_any || (count_q != '0);

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && count_q == DEPTH_C));

endmodule

// File: tb/tb_etc1_block_sequencer.sv
// tb/tb_etc1_block_sequencer.sv - Self-checking bench for etc1_block_sequencer with a reference ETC1 decoder.
module tb_etc1_block_sequencer;
  typedef struct packed { logic [23:0] pix; logic [1:0] x; logic [1:0] y; logic last; } beat_t;
  typedef struct packed {
    logic fire; logic acc; logic in_ready; logic out_valid; logic busy;
    logic [1:0] dec_x; logic [1:0] dec_y; beat_t beat;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        in_valid_v = 1'b0;
  logic [63:0] in_block_v = '0;
  logic        out_ready_v = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] feed[$];
  beat_t       exp_q[$];

  etc1_block_sequencer_if bus1 ();
  etc1_block_sequencer_if bus3 ();

  etc1_block_sequencer #(.DEC_LATENCY(1), .FIFO_DEPTH(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  etc1_block_sequencer #(.DEC_LATENCY(3), .FIFO_DEPTH(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  assign bus1.in_valid  = in_valid_v && (sel == 0);
  assign bus3.in_valid  = in_valid_v && (sel == 1);
  assign bus1.in_block  = in_block_v;
  assign bus3.in_block  = in_block_v;
  assign bus1.out_ready = out_ready_v;
  assign bus3.out_ready = out_ready_v;

  logic        m_in_ready, m_out_valid, m_busy, m_out_last;
  logic [23:0] m_out_pixel;
  logic [1:0]  m_out_x, m_out_y, m_dec_x, m_dec_y;
  logic [63:0] m_dec_block;
  assign m_in_ready  = (sel == 0) ? bus1.in_ready  : bus3.in_ready;
  assign m_out_valid = (sel == 0) ? bus1.out_valid : bus3.out_valid;
  assign m_busy      = (sel == 0) ? bus1.busy      : bus3.busy;
  assign m_out_last  = (sel == 0) ? bus1.out_last  : bus3.out_last;
  assign m_out_pixel = (sel == 0) ? bus1.out_pixel : bus3.out_pixel;
  assign m_out_x     = (sel == 0) ? bus1.out_x     : bus3.out_x;
  assign m_out_y     = (sel == 0) ? bus1.out_y     : bus3.out_y;
  assign m_dec_x     = (sel == 0) ? bus1.dec_x     : bus3.dec_x;
  assign m_dec_y     = (sel == 0) ? bus1.dec_y     : bus3.dec_y;
  assign m_dec_block = (sel == 0) ? bus1.dec_block : bus3.dec_block;

  // Standalone ETC1 texel decode (individual and differential modes).
  function automatic logic [23:0] etc1_ref(input logic [63:0] b, input int x, input int y);
    int lo [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
    int hi [8] = '{8, 17, 29, 42, 60, 80, 106, 183};
    logic [23:0] px;
    int sub, t, i, mag, base, c5, d, ch;
    sub = b[32] ? int'(y >= 2) : int'(x >= 2);
    t   = (sub != 0) ? int'(b[36:34]) : int'(b[39:37]);
    i   = x * 4 + y;
    mag = b[i] ? hi[t] : lo[t];
    if (b[16 + i]) mag = -mag;
    px = '0;
    for (int k = 0; k < 3; k++) begin
      if (b[33]) begin
        c5 = int'(b[63 - 8*k -: 5]);
        d  = int'(b[58 - 8*k -: 3]);
        if (d >= 4) d = d - 8;
        if (sub != 0) c5 = (c5 + d) & 31;
        base = (c5 << 3) | (c5 >> 2);
      end else begin
        base = (sub != 0) ? int'(b[59 - 8*k -: 4]) * 17 : int'(b[63 - 8*k -: 4]) * 17;
      end
      ch = base + mag;
      if (ch < 0) ch = 0;
      if (ch > 255) ch = 255;
      px[23 - 8*k -: 8] = 8'(ch);
    end
    return px;
  endfunction

  logic [23:0] dec1_q;
  logic [23:0] dec3_q [3];
  always @(posedge clk) begin
    dec1_q    <= etc1_ref(bus1.dec_block, int'(bus1.dec_x), int'(bus1.dec_y));
    dec3_q[0] <= etc1_ref(bus3.dec_block, int'(bus3.dec_x), int'(bus3.dec_y));
    dec3_q[1] <= dec3_q[0];
    dec3_q[2] <= dec3_q[1];
  end
  assign bus1.dec_pixel = dec1_q;
  assign bus3.dec_pixel = dec3_q[2];

  task automatic expect_block(input logic [63:0] b);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back('{pix: etc1_ref(b, x, y), x: 2'(x), y: 2'(y), last: (x == 3 && y == 3)});
  endtask

  // One clock: present inputs at the falling edge, sample, then let the rising edge happen.
  task automatic step(input logic rdy, output obs_t o);
    @(negedge clk);
    in_valid_v  = (feed.size() > 0);
    in_block_v  = in_valid_v ? feed[0] : '0;
    out_ready_v = rdy;
    #1;
    o.acc       = m_in_ready && in_valid_v;
    o.fire      = m_out_valid && out_ready_v;
    o.in_ready  = m_in_ready;
    o.out_valid = m_out_valid;
    o.busy      = m_busy;
    o.dec_x     = m_dec_x;
    o.dec_y     = m_dec_y;
    o.beat      = '{pix: m_out_pixel, x: m_out_x, y: m_out_y, last: m_out_last};
    @(posedge clk);
    if (o.acc) void'(feed.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (m_in_ready !== 1'b0 || m_out_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b want 0 0 0", m_in_ready, m_out_valid, m_busy);
    end
    checks++;
    if (m_dec_block !== 64'd0 || m_dec_x !== 2'd0 || m_dec_y !== 2'd0) begin
      errors++; $display("FAIL reset_dec block=%h x=%0d y=%0d want 0 0 0", m_dec_block, m_dec_x, m_dec_y);
    end
    checks++;
    if (m_out_pixel !== 24'd0 || m_out_x !== 2'd0 || m_out_y !== 2'd0 || m_out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out pix=%h x=%0d y=%0d last=%b want all 0", m_out_pixel, m_out_x, m_out_y, m_out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready=%b want 1", m_in_ready); end
  endtask

  task automatic test_idle();
    obs_t o;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, o);
      checks++;
      if (o.in_ready !== 1'b1 || o.out_valid !== 1'b0 || o.busy !== 1'b0 || o.dec_x !== 2'd0 || o.dec_y !== 2'd0) begin
        errors++;
        $display("FAIL idle[%0d] in_ready=%b out_valid=%b busy=%b dec=%0d,%0d want 1 0 0 0,0",
                 i, o.in_ready, o.out_valid, o.busy, o.dec_x, o.dec_y);
      end
    end
  endtask

  task automatic test_single();
    obs_t o; beat_t e;
    int acc_step = -1, first_v = -1, first_b = -1, last_b = -1, n = 0;
    feed.push_back(64'h0123456789abcdef);
    expect_block(64'h0123456789abcdef);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, o);
      if (o.acc && acc_step < 0) acc_step = i;
      if (o.out_valid && first_v < 0) first_v = i;
      if (o.fire) begin
        n++;
        if (first_b < 0) first_b = i;
        last_b = i;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (o.beat !== e) begin
          errors++;
          $display("FAIL single_beat[%0d] got pix=%h x=%0d y=%0d last=%b want pix=%h x=%0d y=%0d last=%b",
                   n, o.beat.pix, o.beat.x, o.beat.y, o.beat.last, e.pix, e.x, e.y, e.last);
        end
      end
    end
    checks++;
    if (first_v - acc_step != 4) begin
      errors++; $display("FAIL single_latency got %0d want %0d", first_v - acc_step, 4);
    end
    checks++;
    if (n != 16 || last_b - first_b != 15) begin
      errors++; $display("FAIL single_count beats=%0d span=%0d want 16 15", n, last_b - first_b);
    end
    checks++;
    if (o.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end busy=%b want 0", o.busy); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    obs_t o; beat_t e;
    int acc1 = -1, acc2 = -1, first_b = -1, last_b = -1, n = 0, rdy_between = 0;
    logic rdy_hist [80];
    feed.push_back(64'h0123456789abcdef);
    feed.push_back(64'hffffffffffffffff);
    expect_block(64'h0123456789abcdef);
    expect_block(64'hffffffffffffffff);
    for (int i = 0; i < 80; i++) begin
      step(1'b1, o);
      rdy_hist[i] = o.in_ready;
      if (o.acc) begin
        if (acc1 < 0) acc1 = i;
        else if (acc2 < 0) acc2 = i;
      end
      if (o.fire) begin
        n++;
        if (first_b < 0) first_b = i;
        last_b = i;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (o.beat !== e) begin
          errors++;
          $display("FAIL b2b_beat[%0d] got pix=%h x=%0d y=%0d last=%b want pix=%h x=%0d y=%0d last=%b",
                   n, o.beat.pix, o.beat.x, o.beat.y, o.beat.last, e.pix, e.x, e.y, e.last);
        end
      end
    end
    for (int i = acc1 + 1; i < acc2 && i >= 0; i++) if (rdy_hist[i] === 1'b1) rdy_between++;
    checks++;
    if (acc1 < 0 || acc2 - acc1 != 16 || rdy_between != 0) begin
      errors++; $display("FAIL b2b_accept gap=%0d in_ready_between=%0d want 16 0", acc2 - acc1, rdy_between);
    end
    checks++;
    if (n != 32 || last_b - first_b != 31) begin
      errors++; $display("FAIL b2b_count beats=%0d span=%0d want 32 31", n, last_b - first_b);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    obs_t o; beat_t e, held;
    logic [1:0] dx, dy;
    logic rdy;
    int n = 0, stall = 0;
    held = '0; dx = '0; dy = '0;
    feed.push_back(64'h8d3f21a05c77e9b4);
    expect_block(64'h8d3f21a05c77e9b4);
    for (int i = 0; i < 80; i++) begin
      rdy = !(n >= 2 && stall < 10);
      step(rdy, o);
      if (!rdy) begin
        stall++;
        if (stall == 1) held = o.beat;
        else begin
          checks++;
          if (o.out_valid !== 1'b1 || o.beat !== held) begin
            errors++;
            $display("FAIL bp_stable[%0d] valid=%b pix=%h x=%0d y=%0d want valid=1 pix=%h x=%0d y=%0d",
                     stall, o.out_valid, o.beat.pix, o.beat.x, o.beat.y, held.pix, held.x, held.y);
          end
        end
        if (stall == 5) begin dx = o.dec_x; dy = o.dec_y; end
        if (stall > 5) begin
          checks++;
          if (o.dec_x !== dx || o.dec_y !== dy) begin
            errors++; $display("FAIL bp_issue_stall dec=%0d,%0d want %0d,%0d", o.dec_x, o.dec_y, dx, dy);
          end
        end
      end
      if (o.fire) begin
        n++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (o.beat !== e) begin
          errors++;
          $display("FAIL bp_beat[%0d] got pix=%h x=%0d y=%0d last=%b want pix=%h x=%0d y=%0d last=%b",
                   n, o.beat.pix, o.beat.x, o.beat.y, o.beat.last, e.pix, e.x, e.y, e.last);
        end
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL bp_count beats=%0d want 16", n); end
    exp_q.delete();
  endtask

  task automatic test_random(input int s);
    obs_t o; beat_t e;
    logic [63:0] b;
    int n = 0, i = 0;
    logic started = 1'b0;
    sel = s;
    for (int k = 0; k < 8; k++) begin
      b = {$urandom(), $urandom()};
      feed.push_back(b);
      expect_block(b);
    end
    while (i < 3000 && n < 128) begin
      step(1'($urandom_range(0, 1)), o);
      i++;
      if (started) begin
        checks++;
        if (o.busy !== 1'b1) begin errors++; $display("FAIL rand%0d_busy step=%0d busy=%b want 1", s, i, o.busy); end
      end
      if (o.acc) started = 1'b1;
      if (o.fire) begin
        n++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (o.beat !== e) begin
          errors++;
          $display("FAIL rand%0d_beat[%0d] got pix=%h x=%0d y=%0d last=%b want pix=%h x=%0d y=%0d last=%b",
                   s, n, o.beat.pix, o.beat.x, o.beat.y, o.beat.last, e.pix, e.x, e.y, e.last);
        end
      end
    end
    checks++;
    if (n != 128) begin errors++; $display("FAIL rand%0d_count beats=%0d want 128", s, n); end
    step(1'b1, o);
    checks++;
    if (o.busy !== 1'b0 || o.out_valid !== 1'b0) begin
      errors++; $display("FAIL rand%0d_busy_end busy=%b out_valid=%b want 0 0", s, o.busy, o.out_valid);
    end
    exp_q.delete();
    feed.delete();
    sel = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o; beat_t e;
    int n = 0;
    feed.push_back(64'h5a5a_0f0f_c3c3_9669);
    expect_block(64'h5a5a_0f0f_c3c3_9669);
    for (int i = 0; i < 40 && n < 5; i++) begin
      step(1'b1, o);
      if (o.fire) n++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b0 || m_in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async out_valid=%b busy=%b in_ready=%b want 0 0 0", m_out_valid, m_busy, m_in_ready);
    end
    feed.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release in_ready=%b out_valid=%b want 1 0", m_in_ready, m_out_valid);
    end
    feed.push_back(64'h1357_9bdf_2468_ace0);
    expect_block(64'h1357_9bdf_2468_ace0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, o);
      if (o.fire) begin
        n++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (o.beat !== e) begin
          errors++;
          $display("FAIL rst_mid_beat[%0d] got pix=%h x=%0d y=%0d last=%b want pix=%h x=%0d y=%0d last=%b",
                   n, o.beat.pix, o.beat.x, o.beat.y, o.beat.last, e.pix, e.x, e.y, e.last);
        end
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL rst_mid_count beats=%0d want 16", n); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
